// File: rtl/uart_pkt_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkt_parser
//  Description : Byte-level packet parser between the UART receiver stream
//                and the ALU command datapath. Consumes a 4-byte header
//                (opcode, reserved, len LSB, len MSB; len counts the whole
//                packet), forwards the len-4 payload bytes on a registered
//                AXI-stream output with tlast, and publishes opcode/length
//                as sideband. Bad opcodes / lengths are flagged and dropped.
//  Ports       : clk_i, reset_i        clock, async active-high reset
//                s_axis_*              byte input from UART receiver
//                m_axis_*              payload byte output (one-entry reg)
//                opcode_o, length_o    sideband of the current packet
//                cmd_start_o           pulse: valid header completed
//                err_o                 pulse: bad opcode or length
//  Revision    : 1.0  initial release
// ============================================================================
module uart_pkt_parser #(
  parameter logic [7:0] OpEcho = 8'hEC,
  parameter logic [7:0] OpAdd  = 8'hAD,
  parameter logic [7:0] OpMul  = 8'h88,
  parameter logic [7:0] OpDiv  = 8'h99
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [7:0]  opcode_o,
  output logic [15:0] length_o,
  output logic        cmd_start_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_RSV     = 3'd1,
    S_LEN_LO  = 3'd2,
    S_LEN_HI  = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DROP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_op_q, hdr_op_d;     // opcode of the header being parsed
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] cnt_q, cnt_d;           // bytes remaining after the current one
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  opcode_q, opcode_d;     // published sideband
  logic [15:0] length_q, length_d;
  logic        cmd_start_q, cmd_start_d;
  logic        err_q, err_d;

  logic        s_xfer;
  logic [15:0] hdr_len;
  logic        op_ok;

  // Only the payload state can stall: the single output register must be
  // empty or draining this cycle before a new byte can be loaded.
  always_comb begin
    s_axis_tready = 1'b1;
    if (state_q == S_PAYLOAD) begin
      s_axis_tready = !tvalid_q || m_axis_tready;
    end
  end

  assign s_xfer  = s_axis_tvalid && s_axis_tready;
  assign hdr_len = {s_axis_tdata, len_lo_q};
  assign op_ok   = (hdr_op_q == OpEcho) || (hdr_op_q == OpAdd) ||
                   (hdr_op_q == OpMul)  || (hdr_op_q == OpDiv);

  always_comb begin
    state_d     = state_q;
    hdr_op_d    = hdr_op_q;
    len_lo_d    = len_lo_q;
    cnt_d       = cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    opcode_d    = opcode_q;
    length_d    = length_q;
    cmd_start_d = 1'b0;
    err_d       = 1'b0;

    // The output register drains independently of the parser state, so a
    // final payload byte may still complete while the next header is parsed.
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      S_OPCODE: begin
        if (s_xfer) begin
          hdr_op_d = s_axis_tdata;
          state_d  = S_RSV;
        end
      end
      S_RSV: begin
        if (s_xfer) begin
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (s_xfer) begin
          len_lo_d = s_axis_tdata;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (s_xfer) begin
          // Counter holds "bytes left after this one", hence len-5.
          cnt_d = (hdr_len > 16'd4) ? (hdr_len - 16'd5) : 16'd0;
          if (op_ok && (hdr_len >= 16'd4)) begin
            cmd_start_d = 1'b1;
            opcode_d    = hdr_op_q;
            length_d    = hdr_len;
            state_d     = (hdr_len == 16'd4) ? S_OPCODE : S_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            state_d = (hdr_len > 16'd4) ? S_DROP : S_OPCODE;
          end
        end
      end
      S_PAYLOAD: begin
        if (s_xfer) begin
          tdata_d  = s_axis_tdata;
          tvalid_d = 1'b1;
          tlast_d  = (cnt_q == 16'd0);
          if (cnt_q == 16'd0) begin
            state_d = S_OPCODE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      S_DROP: begin
        if (s_xfer) begin
          if (cnt_q == 16'd0) begin
            state_d = S_OPCODE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
      end
      default: begin
        state_d = S_OPCODE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_OPCODE;
      hdr_op_q    <= 8'd0;
      len_lo_q    <= 8'd0;
      cnt_q       <= 16'd0;
      tdata_q     <= 8'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      opcode_q    <= 8'd0;
      length_q    <= 16'd0;
      cmd_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_op_q    <= hdr_op_d;
      len_lo_q    <= len_lo_d;
      cnt_q       <= cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      opcode_q    <= opcode_d;
      length_q    <= length_d;
      cmd_start_q <= cmd_start_d;
      err_q       <= err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign opcode_o      = opcode_q;
  assign length_o      = length_q;
  assign cmd_start_o   = cmd_start_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_pkt_parser.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_pkt_parser
//  Description : Self-checking bench for uart_pkt_parser. A packet-level
//                model predicts sideband, pulses and payload stream; directed
//                packets with hand-computed expectations pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_pkt_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  opcode_o;
  logic [15:0] length_o;
  logic        cmd_start_o;
  logic        err_o;

  uart_pkt_parser dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .opcode_o     (opcode_o),
    .length_o     (length_o),
    .cmd_start_o  (cmd_start_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model + per-cycle compare ----------------
  logic [7:0] mq_data[$];
  bit         mq_last[$];
  logic [7:0] log_data[$];
  bit         log_last[$];
  int         n_cmd = 0;
  int         n_err = 0;

  int          m_pos;
  logic [7:0]  m_hdr[4];
  int          m_remain;
  bit          m_good;
  bit          exp_cmd, exp_err;
  logic [7:0]  exp_op;
  logic [15:0] exp_len;
  bit          prev_stall;
  logic [7:0]  prev_data;
  bit          prev_last;

  always @(negedge clk) begin : p_model
    int len;
    if (rst) begin
      mq_data.delete(); mq_last.delete();
      m_pos = 0; m_remain = 0; m_good = 0;
      exp_cmd = 0; exp_err = 0; exp_op = 8'h00; exp_len = 16'h0000;
      prev_stall = 0;
    end else begin
      chk("cmd_start_o", cmd_start_o, exp_cmd);
      chk("err_o", err_o, exp_err);
      chk("opcode_o", opcode_o, exp_op);
      chk("length_o", length_o, exp_len);
      if (m_pos >= 4 && m_good) chk("s_tready payload", s_tready, !m_tvalid || m_tready);
      else                      chk("s_tready header", s_tready, 1);
      if (prev_stall) begin
        chk("stall tdata stable", m_tdata, prev_data);
        chk("stall tlast stable", m_tlast, prev_last);
      end
      if (m_tvalid) begin
        if (mq_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected output: got byte %0h, expected no valid", m_tdata);
        end else begin
          chk("m_tdata", m_tdata, mq_data[0]);
          chk("m_tlast", m_tlast, mq_last[0]);
          if (m_tready) begin
            log_data.push_back(m_tdata); log_last.push_back(m_tlast);
            void'(mq_data.pop_front()); void'(mq_last.pop_front());
          end
        end
      end else begin
        chk("pending payload count", mq_data.size(), 0);
      end
      n_cmd += int'(cmd_start_o);
      n_err += int'(err_o);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;

      // predict the effect of this cycle's input transfer
      exp_cmd = 0; exp_err = 0;
      if (s_tvalid && s_tready) begin
        if (m_pos < 4) begin
          m_hdr[m_pos] = s_tdata;
          m_pos++;
          if (m_pos == 4) begin
            len = int'({m_hdr[3], m_hdr[2]});
            m_good = (m_hdr[0] inside {8'hEC, 8'hAD, 8'h88, 8'h99}) && (len >= 4);
            if (m_good) begin
              exp_cmd = 1; exp_op = m_hdr[0]; exp_len = len[15:0];
            end else begin
              exp_err = 1;
            end
            m_remain = (len > 4) ? len - 4 : 0;
            if (m_remain == 0) m_pos = 0;
          end
        end else begin
          if (m_good) begin
            mq_data.push_back(s_tdata); mq_last.push_back(m_remain == 1);
          end
          m_remain--;
          if (m_remain == 0) m_pos = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx[$];
  logic [7:0] ed[$];
  bit         el[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 0; n = 0;
    s_tvalid = 1'b1; s_tdata = b;
    while (!acc && n < 200) begin
      @(negedge clk); acc = s_tready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send timeout: byte %0h not accepted, expected accept within 200 cycles", b);
    end
  endtask

  task automatic send_tx();
    foreach (tx[i]) send_byte(tx[i]);
  endtask

  task automatic chk_log(input string name, input int mark);
    chk({name, " count"}, log_data.size() - mark, ed.size());
    for (int i = 0; i < ed.size() && mark + i < log_data.size(); i++) begin
      chk({name, " data"}, log_data[mark + i], ed[i]);
      chk({name, " last"}, log_last[mark + i], el[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mk, mc, me, t0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    @(posedge clk); #2;
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset m_tlast", m_tlast, 0);
    chk("reset m_tdata", m_tdata, 0);
    chk("reset opcode_o", opcode_o, 0);
    chk("reset length_o", length_o, 0);
    chk("reset cmd_start", cmd_start_o, 0);
    chk("reset err", err_o, 0);
    chk("reset s_tready", s_tready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Echo
    mk = log_data.size(); mc = n_cmd; me = n_err;
    tx = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h42, 8'h69}; send_tx(); idle(4);
    ed = '{8'h42, 8'h69}; el = '{0, 1}; chk_log("echo", mk);
    chk("echo cmd pulses", n_cmd - mc, 1);
    chk("echo err pulses", n_err - me, 0);
    chk("echo opcode", opcode_o, 8'hEC);
    chk("echo length", length_o, 16'h0006);

    // Backpressure
    mk = log_data.size();
    m_tready = 1'b0;
    fork
      begin
        tx = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h42, 8'h69}; send_tx(); s_tvalid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!m_tvalid && n < 100) begin @(negedge clk); n++; end
        chk("bp first valid", m_tvalid, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp stalled data", m_tdata, 8'h42);
          chk("bp stalled s_tready", s_tready, 0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
      end
    join
    idle(4);
    ed = '{8'h42, 8'h69}; el = '{0, 1}; chk_log("bp", mk);

    // Unknown opcode, then good packet
    mk = log_data.size(); mc = n_cmd; me = n_err;
    tx = '{8'h55, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33,
           8'hEC, 8'h00, 8'h05, 8'h00, 8'hAA};
    send_tx(); idle(4);
    ed = '{8'hAA}; el = '{1}; chk_log("unknown", mk);
    chk("unknown err pulses", n_err - me, 1);
    chk("unknown cmd pulses", n_cmd - mc, 1);
    chk("unknown opcode", opcode_o, 8'hEC);
    chk("unknown length", length_o, 16'h0005);

    // Short lengths
    mk = log_data.size(); mc = n_cmd; me = n_err;
    tx = '{8'hAD, 8'h00, 8'h04, 8'h00}; send_tx(); idle(3);
    chk("len4 cmd pulses", n_cmd - mc, 1);
    chk("len4 no payload", log_data.size() - mk, 0);
    chk("len4 opcode", opcode_o, 8'hAD);
    chk("len4 length", length_o, 16'h0004);
    mc = n_cmd;
    tx = '{8'h88, 8'h00, 8'h02, 8'h00}; send_tx(); idle(3);
    chk("len2 err pulses", n_err - me, 1);
    chk("len2 no cmd", n_cmd - mc, 0);
    chk("len2 opcode kept", opcode_o, 8'hAD);
    tx = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h01}; send_tx(); idle(4);
    ed = '{8'h01}; el = '{1}; chk_log("after len2", mk);
    chk("after len2 opcode", opcode_o, 8'hEC);

    // Back-to-back full throughput
    mk = log_data.size(); mc = n_cmd;
    tx = {};
    ed = {}; el = {};
    for (int p = 0; p < 2; p++) begin
      tx.push_back(8'hAD); tx.push_back(8'h00); tx.push_back(8'h0C); tx.push_back(8'h00);
      for (int i = 0; i < 8; i++) begin
        tx.push_back(8'(8'h10 * (p + 1) + i));
        ed.push_back(8'(8'h10 * (p + 1) + i));
        el.push_back(i == 7);
      end
    end
    t0 = cyc;
    send_tx();
    chk("b2b cycles", cyc - t0, 24);
    idle(4);
    chk_log("b2b", mk);
    chk("b2b cmd pulses", n_cmd - mc, 2);
    chk("b2b length", length_o, 16'h000C);

    // Reset mid-payload
    tx = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02}; send_tx();
    s_tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid reset m_tvalid", m_tvalid, 0);
    chk("mid reset m_tlast", m_tlast, 0);
    chk("mid reset opcode", opcode_o, 0);
    chk("mid reset length", length_o, 0);
    chk("mid reset s_tready", s_tready, 1);
    tick(); tick();
    rst = 1'b0;
    tick();
    mk = log_data.size();
    tx = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E}; send_tx(); idle(4);
    ed = '{8'h7E}; el = '{1}; chk_log("post reset", mk);
    chk("post reset opcode", opcode_o, 8'hEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_pkt_parser.md
Name: uart_pkt_parser

Overview:
- Byte-level packet parser between the UART receiver's AXI-stream output and the ALU command datapath.
- Consumes a 4-byte header: opcode, reserved, length LSB, length MSB. Length is little-endian and counts the whole packet including the header.
- Forwards the remaining length-4 payload bytes on a registered AXI-stream output with tlast on the final byte.
- Presents the opcode and length as stable sideband for the whole packet. Unknown opcodes and malformed lengths are dropped and flagged.

Parameters:
- OpEcho, 8'hEC, echo opcode
- OpAdd, 8'hAD, 32-bit add opcode
- OpMul, 8'h88, 32-bit multiply opcode
- OpDiv, 8'h99, 32-bit divide opcode

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- s_axis_tdata  in  8  byte from UART receiver
- s_axis_tvalid  in  1  input byte valid
- s_axis_tready  out  1  parser accepts input byte
- m_axis_tdata  out  8  payload byte
- m_axis_tvalid  out  1  payload byte valid
- m_axis_tready  in  1  downstream accepts payload
- m_axis_tlast  out  1  last payload byte of packet
- opcode_o  out  8  opcode of current packet, stable from cmd_start_o until the next packet's header completes
- length_o  out  16  total packet length, same stability as opcode_o
- cmd_start_o  out  1  one-cycle pulse when a valid header completes
- err_o  out  1  one-cycle pulse on a bad opcode or length

Behaviour:
- Reset (asynchronous assert, release synchronous to clk_i):
  - state = OPCODE.
  - m_axis_tvalid, m_axis_tlast, cmd_start_o, err_o = 0.
  - m_axis_tdata, opcode_o, length_o = 0.
  - Payload counter = 0.
- A transfer occurs on a rising edge with s_axis_tvalid && s_axis_tready.
- Header states: s_axis_tready = 1 in OPCODE, RSV, LEN_LO, LEN_HI and DROP.
  - OPCODE: capture the byte into the opcode register, go to RSV.
  - RSV: the byte is ignored (any value), go to LEN_LO.
  - LEN_LO: capture the low length byte, go to LEN_HI.
  - LEN_HI: capture the high length byte and form len = {hi, lo}. Next cycle:
    - Opcode not in {OpEcho, OpAdd, OpMul, OpDiv}, or len < 4: pulse err_o. If len > 4, go to DROP with counter = len-5; otherwise go to OPCODE. cmd_start_o is not pulsed.
    - Valid opcode, len == 4: pulse cmd_start_o, update opcode_o/length_o, go to OPCODE. No payload is produced.
    - Valid opcode, len > 4: pulse cmd_start_o, update opcode_o/length_o, go to PAYLOAD with counter = len-5.
- PAYLOAD:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (one-entry output register).
  - On an input transfer: load m_axis_tdata, set m_axis_tvalid = 1, set m_axis_tlast = (counter == 0). If counter == 0 go to OPCODE, else decrement the counter.
  - m_axis_tvalid clears after an output transfer with no simultaneous load.
  - A simultaneous output transfer and input load keeps m_axis_tvalid = 1 and gives full throughput.
- DROP: accept and discard bytes. At counter == 0 go to OPCODE, else decrement. The m_axis outputs are untouched.
- The last payload byte may still be pending in the output register after returning to OPCODE. Header parsing of the next packet proceeds; the pending output is unaffected.
- Latency: header byte 4 accepted at edge N → cmd_start_o high in cycle N+1. Payload byte accepted at edge N → m_axis_tvalid high in cycle N+1.
- Output stability: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast are held stable.
- Length arithmetic is 16-bit unsigned. Maximum len 16'hFFFF gives 65531 payload bytes; no wrap occurs.
- Reset asserted mid-packet aborts immediately to the reset state; the partial packet is lost.

Test Plan:
- Echo: send EC 00 06 00 42 69 with m_axis_tready = 1. Required: cmd_start_o pulses once; opcode_o = EC; length_o = 0006; payload 42 (tlast = 0) then 69 (tlast = 1); err_o never asserts.
- Backpressure: same packet with m_axis_tready held 0 for 5 cycles after the first valid. Required: m_axis_tdata = 42 stable while stalled; s_axis_tready = 0 during the stall; 69 delivered afterwards with tlast = 1.
- Unknown opcode: send 55 00 07 00 11 22 33, then EC 00 05 00 AA. Required: err_o pulses once; 11/22/33 never appear on m_axis; then payload AA with tlast = 1 and opcode_o = EC.
- Short lengths: AD 00 04 00 → cmd_start_o pulses, no payload. 88 00 02 00 → err_o pulses, parser back in OPCODE, and a following EC 00 05 00 01 is parsed correctly.
- Back-to-back: two 12-byte AD packets (8 payload bytes each) with continuous valid and ready. Required: 16 payload bytes with tlast on bytes 8 and 16; two cmd_start_o pulses.
- Reset mid-payload: assert reset_i asynchronously between clock edges during PAYLOAD. Required: m_axis_tvalid = 0 and state = OPCODE immediately; a subsequent EC 00 05 00 7E outputs 7E with tlast = 1.
